// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type, clog2 helper and default parameters
// for the set-associative write-back cache.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_e;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SETS   = 4;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_CNT_W  = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cache_lru_set.sv
// cache_lru_set: age-based LRU state of one set; ages stay a permutation of
// 0..WAYS-1, the victim is the lowest invalid way or else the oldest way.
module cache_lru_set
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  localparam int WW = clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_i,
  input  logic [WW-1:0]   way_i,
  input  logic [WAYS-1:0] valid_i,
  output logic [WW-1:0]   victim_o
);
  logic [WW-1:0] age_q [WAYS];
  logic [WW-1:0] age_d [WAYS];
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      age_d[w] = !acc_i ? age_q[w] :
                 (WW'(w) == way_i) ? '0 :
                 (age_q[w] < age_q[way_i]) ? age_q[w] + 1'b1 : age_q[w];
    victim_o = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[w] == WW'(WAYS - 1)) victim_o = WW'(w);
    // invalid ways take precedence over the oldest one
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_i[w]) victim_o = WW'(w);
  end
  always_ff @(posedge clk) begin
    if (!rst)
      for (int w = 0; w < WAYS; w++) age_q[w] <= WW'(w);
    else
      age_q <= age_d;
  end
endmodule

// File: rtl/param_cache.sv
// param_cache: N-way set-associative write-back/write-allocate cache with
// one-word lines, LRU replacement, req/ack memory port and statistics.
module param_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              report,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses,
  output logic [CNT_W-1:0]  stat_wbs
);
  localparam int IW = clog2(SETS);
  localparam int WW = clog2(WAYS);
  localparam int TW = ADDR_W - IW;
  logic [DATA_W-1:0] cachemem [SETS][WAYS];
  logic [TW-1:0]     tags     [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   dirty_q  [SETS];
  logic [WW-1:0]     victim_s [SETS];
  state_e            state_q, state_d;
  logic              we_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WW-1:0]     way_q, way_d;
  logic [CNT_W-1:0]  hits_q, misses_q, wbs_q, hits_d, misses_d, wbs_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [IW-1:0]     cidx;
  logic [TW-1:0]     ctag;
  logic              accept, hit, lru_acc, ln_we, ln_dirty, inv, inc_h, inc_m, inc_w;
  logic [WW-1:0]     hit_way, victim;
  logic [DATA_W-1:0] ln_data;
  // outside IDLE every lookup refers to the latched request
  assign accept   = state_q == IDLE && req_valid;
  assign cur_addr = state_q == IDLE ? address : addr_q;
  assign cidx     = cur_addr[IW-1:0];
  assign ctag     = cur_addr[ADDR_W-1:IW];
  assign victim   = victim_s[cidx];
  for (genvar s = 0; s < SETS; s++) begin : g_set
    cache_lru_set #(.WAYS(WAYS)) u_lru (
      .clk      (clk),
      .rst      (rst),
      .acc_i    (lru_acc && cidx == IW'(s)),
      .way_i    (way_d),
      .valid_i  (valid_q[s]),
      .victim_o (victim_s[s])
    );
  end
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid_q[cidx][w] && tags[cidx][w] == ctag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
  end
  always_comb begin
    state_d = state_q;
    way_d = way_q;
    lru_acc = 1'b0;
    ln_we = 1'b0;
    ln_data = wdata_q;
    ln_dirty = 1'b1;
    inv = 1'b0;
    inc_h = 1'b0;
    inc_m = 1'b0;
    inc_w = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        way_d = hit ? hit_way : victim;
        inc_h = hit;
        inc_m = !hit;
        ln_data = write_data;
        if (hit) begin
          lru_acc = 1'b1;
          ln_we = write_en;
          state_d = RESPOND;
        end else if (valid_q[cidx][victim] && dirty_q[cidx][victim]) begin
          state_d = WRITEBACK;
        end else if (write_en) begin
          lru_acc = 1'b1;
          ln_we = 1'b1;
          state_d = RESPOND;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: if (mem_ack) begin
        inc_w = 1'b1;
        inv = 1'b1;
        lru_acc = we_q;
        ln_we = we_q;
        state_d = we_q ? RESPOND : FILL;
      end
      FILL: if (mem_ack) begin
        lru_acc = 1'b1;
        ln_we = 1'b1;
        ln_data = mem_rdata;
        ln_dirty = 1'b0;
        state_d = RESPOND;
      end
      default: state_d = IDLE;
    endcase
  end
  assign hits_d   = hits_q + CNT_W'(inc_h && !(&hits_q));
  assign misses_d = misses_q + CNT_W'(inc_m && !(&misses_q));
  assign wbs_d    = wbs_q + CNT_W'(inc_w && !(&wbs_q));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      way_q <= '0;
      we_q <= 1'b0;
      hit_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      hits_q <= '0;
      misses_q <= '0;
      wbs_q <= '0;
      stat_hits <= '0;
      stat_misses <= '0;
      stat_wbs <= '0;
    end else begin
      state_q <= state_d;
      way_q <= way_d;
      if (accept) begin
        we_q <= write_en;
        hit_q <= hit;
        addr_q <= address;
        wdata_q <= write_data;
      end
      hits_q <= hits_d;
      misses_q <= misses_d;
      wbs_q <= wbs_d;
      if (report) begin
        stat_hits <= hits_d;
        stat_misses <= misses_d;
        stat_wbs <= wbs_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '{default: '0};
      dirty_q <= '{default: '0};
    end else begin
      if (inv) valid_q[cidx][way_d] <= 1'b0;
      if (ln_we) begin
        valid_q[cidx][way_d] <= 1'b1;
        dirty_q[cidx][way_d] <= ln_dirty;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst && ln_we) begin
      cachemem[cidx][way_d] <= ln_data;
      tags[cidx][way_d] <= ctag;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESPOND;
  assign resp_hit   = resp_valid && hit_q;
  assign read_data  = resp_valid ? cachemem[cidx][way_q] : '0;
  assign mem_req    = state_q == WRITEBACK || state_q == FILL;
  assign mem_we     = state_q == WRITEBACK;
  assign mem_addr   = mem_we ? {tags[cidx][way_q], cidx} : state_q == FILL ? addr_q : '0;
  assign mem_wdata  = mem_we ? cachemem[cidx][way_q] : '0;
endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: table-driven directed test of param_cache (SETS=4, WAYS=2)
// against a req/ack memory model with programmable ack delay.
module tb_param_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, write_en = 1'b0, report = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic        req_ready, resp_valid, resp_hit, mem_req, mem_we, mem_ack;
  logic [31:0] read_data, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] stat_hits, stat_misses, stat_wbs;
  int compared = 0, mismatched = 0;
  int ack_delay = 1, cnt = 0, stab_err = 0, req_cycles = 0, ready_err = 0;
  logic [31:0] mem [256];
  logic [7:0]  log_a [$];
  logic        log_we [$];
  logic [31:0] log_d [$];
  logic [7:0]  f_a;
  logic        f_we;
  logic [31:0] f_d;
  param_cache dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .write_en(write_en), .address(address), .write_data(write_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .read_data(read_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .report(report),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
  );
  always #5 clk = ~clk;
  // memory model: acks ack_delay cycles after mem_req rises, checks the request stays stable
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          cnt = 0;
        end
        if (!mem_req) cnt = 0;
        else begin
          cnt++;
          req_cycles++;
          if (cnt == 1) begin
            f_a = mem_addr;
            f_we = mem_we;
            f_d = mem_wdata;
          end else if (mem_addr !== f_a || mem_we !== f_we || (f_we && mem_wdata !== f_d)) stab_err++;
          if (cnt > ack_delay) begin
            mem_ack = 1'b1;
            log_a.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_d.push_back(mem_wdata);
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem[mem_addr];
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_req(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output logic hit, output logic [31:0] data, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    write_en = we;
    address = a;
    write_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    hit = 1'bx;
    data = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i;
        hit = resp_hit;
        data = read_data;
        break;
      end
      if (req_ready) ready_err++;
    end
  endtask
  task automatic snap();
    @(negedge clk);
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;
  endtask
  typedef struct {
    logic we; logic [7:0] a; logic [31:0] d;
    logic hit; logic [31:0] rd; int lat; int txn;
  } vec_t;
  vec_t v [17];
  initial begin
    logic h;
    logic [31:0] rd;
    int lat, t0;
    v[0]  = '{1'b0, 8'h20, 32'h0,         1'b0, 32'h1111_0000, 3, 1};
    v[1]  = '{1'b0, 8'h20, 32'h0,         1'b1, 32'h1111_0000, 1, 0};
    v[2]  = '{1'b1, 8'h20, 32'h00AB_CDEF, 1'b1, 32'h00AB_CDEF, 1, 0};
    v[3]  = '{1'b0, 8'h20, 32'h0,         1'b1, 32'h00AB_CDEF, 1, 0};
    v[4]  = '{1'b0, 8'h24, 32'h0,         1'b0, 32'h2222_0000, 3, 1};
    v[5]  = '{1'b0, 8'h28, 32'h0,         1'b0, 32'h3333_0000, 5, 2};
    v[6]  = '{1'b0, 8'h20, 32'h0,         1'b0, 32'h00AB_CDEF, 3, 1};
    v[7]  = '{1'b0, 8'h24, 32'h0,         1'b0, 32'h2222_0000, 3, 1};
    v[8]  = '{1'b0, 8'h20, 32'h0,         1'b1, 32'h00AB_CDEF, 1, 0};
    v[9]  = '{1'b0, 8'h28, 32'h0,         1'b0, 32'h3333_0000, 3, 1};
    v[10] = '{1'b0, 8'h20, 32'h0,         1'b1, 32'h00AB_CDEF, 1, 0};
    v[11] = '{1'b0, 8'h24, 32'h0,         1'b0, 32'h2222_0000, 3, 1};
    v[12] = '{1'b1, 8'h21, 32'hDEAD_0001, 1'b0, 32'hDEAD_0001, 1, 0};
    v[13] = '{1'b0, 8'h21, 32'h0,         1'b1, 32'hDEAD_0001, 1, 0};
    v[14] = '{1'b1, 8'h25, 32'hBEEF_0002, 1'b0, 32'hBEEF_0002, 1, 0};
    v[15] = '{1'b1, 8'h29, 32'hCAFE_0003, 1'b0, 32'hCAFE_0003, 3, 1};
    v[16] = '{1'b0, 8'h21, 32'h0,         1'b0, 32'hDEAD_0001, 5, 2};
    foreach (mem[i]) mem[i] = '0;
    mem[8'h20] = 32'h1111_0000;
    mem[8'h24] = 32'h2222_0000;
    mem[8'h28] = 32'h3333_0000;
    mem[8'h2C] = 32'h4444_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_mem_req", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_stats", {stat_hits, stat_misses}, 0);
    chk("rst_wbs", stat_wbs, 0);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      t0 = log_a.size();
      do_req(v[i].we, v[i].a, v[i].d, h, rd, lat);
      chk($sformatf("v%0d_hit", i), h, v[i].hit);
      chk($sformatf("v%0d_data", i), rd, v[i].rd);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_txns", i), log_a.size() - t0, v[i].txn);
    end
    chk("table_ready_low", ready_err, 0);
    if (log_a.size() >= 11) begin
      chk("wb20_addr", {log_we[2], log_a[2]}, {1'b1, 8'h20});
      chk("wb20_data", log_d[2], 32'h00AB_CDEF);
      chk("fill28_addr", {log_we[3], log_a[3]}, {1'b0, 8'h28});
      chk("wb21", {log_we[8], log_a[8], log_d[8]}, {1'b1, 8'h21, 32'hDEAD_0001});
      chk("wb25", {log_we[9], log_a[9], log_d[9]}, {1'b1, 8'h25, 32'hBEEF_0002});
      chk("fill21_addr", {log_we[10], log_a[10]}, {1'b0, 8'h21});
    end else chk("log_size", log_a.size(), 11);
    // slow memory: request must stay stable and the core port closed
    ack_delay = 5;
    stab_err = 0;
    req_cycles = 0;
    ready_err = 0;
    do_req(1'b0, 8'h2C, 32'h0, h, rd, lat);
    chk("slow_hit", h, 0);
    chk("slow_data", rd, 32'h4444_0000);
    chk("slow_lat", lat, 7);
    chk("slow_req_cycles", req_cycles, 6);
    chk("slow_stable", stab_err, 0);
    chk("slow_ready_low", ready_err, 0);
    snap();
    chk("stat_hits", stat_hits, 6);
    chk("stat_misses", stat_misses, 12);
    chk("stat_wbs", stat_wbs, 3);
    ack_delay = 1;
    do_req(1'b0, 8'h20, 32'h0, h, rd, lat);
    chk("refill20", {h, rd}, {1'b0, 32'h00AB_CDEF});
    // reset while a fill is outstanding
    ack_delay = 5;
    @(negedge clk);
    req_valid = 1'b1;
    write_en = 1'b0;
    address = 8'h28;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fill_pending", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h28});
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstfill_mem_req", {mem_req, mem_addr}, 0);
    chk("rstfill_ready", req_ready, 1);
    chk("rstfill_stats", {stat_hits, stat_misses, stat_wbs}, 0);
    rst = 1'b1;
    ack_delay = 1;
    t0 = log_a.size();
    do_req(1'b0, 8'h20, 32'h0, h, rd, lat);
    chk("post_rst_hit", h, 0);
    chk("post_rst_data", rd, 32'h00AB_CDEF);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_txns", log_a.size() - t0, 1);
    snap();
    chk("post_rst_stats", {stat_hits, stat_misses, stat_wbs}, {32'd0, 32'd1, 32'd0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
